spi_req_arb: RTL
================

# spi_req_arb

Shares one SPI transfer engine among up to REQ_NUM requesters (e.g. CPU register path, DMA, boot flash loader). Arbitrates between pending requests, latches the winner's slave-select and transfer length into the engine, issues the start pulse, and steers the 32-bit TX/RX word streams between the granted requester and the engine. Enforces a minimum idle gap between transfers so slave-select deassert time is guaranteed. Sits between the requesters and the SPI core, inside the SPI subsystem top.

## Interface
- REQ_NUM, 4, number of requesters (2..8)
- TRL_WIDTH, 8, width of transfer-length field (words per transfer)
- GAP_CYC, 2, minimum idle cycles between transfers (0 = none)
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  REQ_NUM  request; held high until done_o
- req_nss_i  in  4*REQ_NUM  slave-select mask per requester (slice k = bits 4k+3:4k)
- req_trl_i  in  TRL_WIDTH*REQ_NUM  words to transfer per requester
- gnt_o  out  REQ_NUM  one-hot grant
- done_o  out  REQ_NUM  one-cycle completion pulse to owning requester
- req_tx_valid_i / req_tx_ready_o  in / out  REQ_NUM  per-requester TX handshake
- req_tx_data_i  in  32*REQ_NUM  TX words
- req_rx_valid_o / req_rx_ready_i  out / in  REQ_NUM  per-requester RX handshake
- req_rx_data_o  out  32  shared RX word (qualified by req_rx_valid_o)
- core_nss_o  out  4  latched slave-select to engine
- core_trl_o  out  TRL_WIDTH  latched length to engine
- core_st_o  out  1  start pulse
- core_busy_i  in  1  engine busy
- core_tx_valid_o / core_tx_ready_i / core_tx_data_o  out / in / out  1/1/32
- core_rx_valid_i / core_rx_ready_o / core_rx_data_i  in / out / in  1/1/32

## Operation
- States: IDLE, GRANT, START, XFER, GAP.
- IDLE: if any req_i is high, select a winner, register gnt_o, core_nss_o, core_trl_o, then go to GRANT; otherwise stay.
- GRANT: one settle cycle, then go to START. Exception: if the latched trl is 0, pulse done_o and go to GAP without starting the engine.
- START: core_st_o=1 for exactly one cycle, clear the RX word counter, then go to XFER.
- XFER: TX/RX handshakes muxed combinationally to the granted index; all non-granted ready/valid outputs are 0. Each core RX handshake increments the counter (TRL_WIDTH bits). When counter==trl and core_busy_i==0: pulse done_o[granted], clear gnt_o, go to GAP.
- GAP: count GAP_CYC cycles with core_nss_o=0, then go to IDLE. If GAP_CYC=0, go directly to IDLE.
- Arbitration (default): round-robin. Search starts at last winner+1 and wraps at REQ_NUM-1→0. After reset the pointer is REQ_NUM-1, so requester 0 has first priority.
- Once granted, req_i deassertion is ignored; the transfer runs to completion. Requests arriving mid-transfer wait for IDLE.
- core_nss_o/core_trl_o are stable from GRANT until leaving XFER.

## Timing
- Reset values: gnt_o=0, done_o=0, core_st_o=0, core_nss_o=0, core_trl_o=0, all ready/valid outputs 0, state IDLE, RR pointer REQ_NUM-1.
- Latency, req_i rising in IDLE to core_st_o: gnt_o at cycle 1, core_st_o at cycle 3.
- done_o is asserted in the same cycle as the completion condition; gnt_o is low from the next cycle.
- Next grant occurs no earlier than GAP_CYC+1 cycles after done_o.
- Reset mid-transfer: all outputs return to reset values on the cycle after rst_i is sampled high. No done_o is issued for the aborted transfer.

## Configuration
- SPI_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, RR pointer logic removed.
- SPI_ARB_FIXED_PRIO_EN undefined: round-robin as described above.

## Test plan
- Single request, req_i=4'b0010, nss=4'b0001, trl=3; model 3 RX words → gnt_o=4'b0010 at cycle 1, core_st_o at cycle 3, core_nss_o=1, done_o[1] after the 3rd RX word with busy low.
- req_i=4'b1111 held continuously → grants in order 0,1,2,3,0. Each next grant ≥GAP_CYC+1 cycles after the previous done_o. With SPI_ARB_FIXED_PRIO_EN defined, grants are 0 repeatedly.
- trl=0 → done_o pulses, core_st_o never asserted, core_nss_o returns to 0.
- Granted requester drops req_i mid-XFER → transfer completes and done_o still pulses. A non-granted requester sees ready/valid held 0 throughout.
- rst_i asserted during XFER with trl=5 after 2 words → next cycle gnt_o=0, core_nss_o=0, state IDLE, no done_o.
- RX backpressure: req_rx_ready_i low for 4 cycles → core_rx_ready_o low for those 4 cycles, no words lost, counter stalls.

Source files
------------

// File: rtl/spi_req_arb.sv
// spi_req_arb: shares one SPI transfer engine among REQ_NUM requesters, steering TX/RX word streams to the granted one.
// Latency: req_i high in IDLE -> gnt_o next cycle -> core_st_o two cycles later; done_o is combinational with completion.
// Backpressure: RX/TX valid-ready pass straight through to the granted requester. Optional SPI_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module spi_req_arb #(
  parameter int REQ_NUM   = 4,
  parameter int TRL_WIDTH = 8,
  parameter int GAP_CYC   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [REQ_NUM-1:0]         req_i,
  input  logic [4*REQ_NUM-1:0]       req_nss_i,
  input  logic [TRL_WIDTH*REQ_NUM-1:0] req_trl_i,
  output logic [REQ_NUM-1:0]         gnt_o,
  output logic [REQ_NUM-1:0]         done_o,
  input  logic [REQ_NUM-1:0]         req_tx_valid_i,
  output logic [REQ_NUM-1:0]         req_tx_ready_o,
  input  logic [32*REQ_NUM-1:0]      req_tx_data_i,
  output logic [REQ_NUM-1:0]         req_rx_valid_o,
  input  logic [REQ_NUM-1:0]         req_rx_ready_i,
  output logic [31:0]                req_rx_data_o,
  output logic [3:0]                 core_nss_o,
  output logic [TRL_WIDTH-1:0]       core_trl_o,
  output logic                       core_st_o,
  input  logic                       core_busy_i,
  output logic                       core_tx_valid_o,
  input  logic                       core_tx_ready_i,
  output logic [31:0]                core_tx_data_o,
  input  logic                       core_rx_valid_i,
  output logic                       core_rx_ready_o,
  input  logic [31:0]                core_rx_data_i
);

  localparam int IDX_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {IDLE, GRANT, START, XFER, GAP} state_e;

  state_e               state_q, state_d;
  logic [REQ_NUM-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [3:0]           nss_q, nss_d;
  logic [TRL_WIDTH-1:0] trl_q, trl_d;
  logic [TRL_WIDTH-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 st_q, st_d;

  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand_idx;
  logic                 in_xfer;
  logic                 xfer_done;
  logic                 zero_len;
  logic                 rx_hs;

`ifndef SPI_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]     rr_q, rr_d;
`endif

  // Winner select: scan from the highest-priority candidate last so it overrides lower ones.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
`ifdef SPI_ARB_FIXED_PRIO_EN
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      cand_idx = IDX_W'(i);
      if (req_i[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
`else
    for (int i = REQ_NUM; i >= 1; i--) begin
      cand_idx = IDX_W'((int'(rr_q) + i) % REQ_NUM);
      if (req_i[cand_idx]) begin
        win_vld = 1'b1;
        win_idx = cand_idx;
      end
    end
`endif
  end

  assign in_xfer   = (state_q == XFER);
  assign zero_len  = (state_q == GRANT) && (trl_q == '0);
  assign xfer_done = in_xfer && (cnt_q == trl_q) && !core_busy_i;
  assign rx_hs     = core_rx_valid_i && core_rx_ready_o;

  // Next-state and register updates for the arbitration/transfer sequence.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    nss_d   = nss_q;
    trl_d   = trl_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    st_d    = 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
    rr_d    = rr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          nss_d          = 4'(req_nss_i >> (4 * int'(win_idx)));
          trl_d          = TRL_WIDTH'(req_trl_i >> (TRL_WIDTH * int'(win_idx)));
`ifndef SPI_ARB_FIXED_PRIO_EN
          rr_d           = win_idx;
`endif
          state_d        = GRANT;
        end
      end
      GRANT: begin
        if (zero_len) begin
          // Nothing to move: complete without ever starting the engine.
          gnt_d = '0;
          nss_d = '0;
          if (GAP_CYC == 0) state_d = IDLE;
          else begin
            state_d = GAP;
            gap_d   = GAP_W'(GAP_CYC - 1);
          end
        end else begin
          state_d = START;
        end
      end
      START: begin
        st_d    = 1'b1;
        cnt_d   = '0;
        state_d = XFER;
      end
      XFER: begin
        if (rx_hs) cnt_d = cnt_q + 1'b1;
        if (xfer_done) begin
          gnt_d = '0;
          nss_d = '0;
          if (GAP_CYC == 0) state_d = IDLE;
          else begin
            state_d = GAP;
            gap_d   = GAP_W'(GAP_CYC - 1);
          end
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else gap_d = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; the round-robin pointer restarts so requester 0 goes first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      nss_q   <= '0;
      trl_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      st_q    <= 1'b0;
`ifndef SPI_ARB_FIXED_PRIO_EN
      rr_q    <= IDX_W'(REQ_NUM - 1);
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      nss_q   <= nss_d;
      trl_q   <= trl_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      st_q    <= st_d;
`ifndef SPI_ARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  assign gnt_o      = gnt_q;
  assign done_o     = (zero_len || xfer_done) ? gnt_q : '0;
  assign core_nss_o = nss_q;
  assign core_trl_o = trl_q;
  assign core_st_o  = st_q;

  // Data-path steering: only the granted requester sees handshakes, and only while transferring.
  always_comb begin
    core_tx_valid_o = in_xfer && req_tx_valid_i[idx_q];
    core_tx_data_o  = 32'(req_tx_data_i >> (32 * int'(idx_q)));
    core_rx_ready_o = in_xfer && req_rx_ready_i[idx_q];
    req_rx_data_o   = core_rx_data_i;
    req_tx_ready_o  = '0;
    req_rx_valid_o  = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      req_tx_ready_o[k] = in_xfer && (idx_q == IDX_W'(k)) && core_tx_ready_i;
      req_rx_valid_o[k] = in_xfer && (idx_q == IDX_W'(k)) && core_rx_valid_i;
    end
  end

endmodule
